// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg
// Shared types and constants for the enemy wave sequencer.
//   wave_state_t : game/wave controller states
//   ENEMY_ID_W   : width of the drawing requestor id carried with hit events
//   SPEED_W      : width of the enemy X speed
//   KILL_W       : width of the kill counter
//   wave_speed() : speed applied at the spawn of a given wave
// ---------------------------------------------------------------------------
package enemy_pkg;

  localparam int ENEMY_ID_W = 4;
  localparam int SPEED_W    = 11;
  localparam int KILL_W     = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    PLAY  = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } wave_state_t;

  // Speed for a wave. The sum is formed in 12 bits, capped at max_speed, then
  // clamped to the 11-bit speed range. With speedup disabled the initial speed
  // is used unchanged for every wave.
  function automatic logic [SPEED_W-1:0] wave_speed(
    input logic [3:0]  wave,
    input logic [11:0] init_speed,
    input logic [11:0] step,
    input logic [11:0] max_speed,
    input logic        speedup_en
  );
    logic [11:0] raw;
    logic [11:0] capped;
    if (speedup_en) begin
      raw    = init_speed + (12'(wave) * step);
      capped = (raw > max_speed) ? max_speed : raw;
    end else begin
      raw    = init_speed;
      capped = raw;
    end
    wave_speed = (capped > 12'd2047) ? 11'd2047 : capped[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/frame_delay_counter.sv
// ---------------------------------------------------------------------------
// frame_delay_counter
// Counts video-frame pulses while enabled and flags when TERMINAL frames have
// been seen. The count holds at TERMINAL until cleared.
//   clk      in  system clock
//   resetN   in  asynchronous active-low reset
//   clear_i  in  synchronous clear of the count (has priority)
//   enable_i in  count frame pulses while high
//   frame_i  in  one-cycle frame pulse
//   done_o   out count has reached TERMINAL
// ---------------------------------------------------------------------------
module frame_delay_counter #(
  parameter int TERMINAL = 60
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear_i,
  input  logic enable_i,
  input  logic frame_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(TERMINAL + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             done_s;

  assign done_s = (count_q == CNT_TERM);
  assign done_o = done_s;

  // Next count: clear wins, otherwise advance on a frame until terminal.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && frame_i && !done_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/enemy_wave_sequencer.sv
// ---------------------------------------------------------------------------
// enemy_wave_sequencer
// Game-level controller for the enemy stock: owns the per-enemy alive map,
// sequences waves (spawn -> play -> clear delay -> next wave) and ends the
// game when an enemy lands or the final wave is cleared.
// Build option: define WAVE_SPEEDUP_EN to raise the enemy speed every wave;
// without it the speed stays at ENEMY_INITIAL_SPEED.
//   clk            in  system clock
//   resetN         in  asynchronous active-low reset
//   startOfFrame   in  one-cycle pulse per video frame
//   startGame      in  one-cycle start/restart request
//   hitPulse       in  one-cycle shot-to-enemy collision
//   hitId          in  id of the enemy hit, valid with hitPulse
//   enemyLanded    in  an alive enemy reached the player line (level)
//   aliveMap       out bit i = enemy i alive
//   enemySpeed     out X speed for all enemies
//   waveNumber     out current wave, 0-based
//   killCount      out kills this game, saturating
//   waveStartPulse out one-cycle pulse: enemies reload initial positions
//   gameOver       out high in OVER and WIN
//   gameWon        out high in WIN
// ---------------------------------------------------------------------------
module enemy_wave_sequencer
  import enemy_pkg::*;
#(
  parameter int AMOUNT_OF_ENEMIES   = 2,
  parameter int ENEMY_INITIAL_SPEED = 120,
  parameter int SPEED_STEP          = 20,
  parameter int MAX_SPEED           = 400,
  parameter int CLEAR_DELAY_FRAMES  = 60,
  parameter int MAX_WAVES           = 8
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         startGame,
  input  logic                         hitPulse,
  input  logic [ENEMY_ID_W-1:0]        hitId,
  input  logic                         enemyLanded,
  output logic [AMOUNT_OF_ENEMIES-1:0] aliveMap,
  output logic [SPEED_W-1:0]           enemySpeed,
  output logic [3:0]                   waveNumber,
  output logic [KILL_W-1:0]            killCount,
  output logic                         waveStartPulse,
  output logic                         gameOver,
  output logic                         gameWon
);

`ifdef WAVE_SPEEDUP_EN
  localparam logic SPEEDUP_EN = 1'b1;
`else
  localparam logic SPEEDUP_EN = 1'b0;
`endif

  localparam logic [AMOUNT_OF_ENEMIES-1:0] ALL_ALIVE  = {AMOUNT_OF_ENEMIES{1'b1}};
  localparam logic [AMOUNT_OF_ENEMIES-1:0] ID0_MASK   = AMOUNT_OF_ENEMIES'(1);
  localparam logic [3:0]                   LAST_WAVE  = 4'(MAX_WAVES - 1);
  localparam logic [KILL_W-1:0]            KILL_MAX   = {KILL_W{1'b1}};
  localparam logic [SPEED_W-1:0]           INIT_SPEED = SPEED_W'(ENEMY_INITIAL_SPEED);

  wave_state_t                  state_q, state_d;
  logic [AMOUNT_OF_ENEMIES-1:0] alive_q, alive_d;
  logic [SPEED_W-1:0]           speed_q, speed_d;
  logic [3:0]                   wave_q, wave_d;
  logic [KILL_W-1:0]            kill_q, kill_d;
  logic                         pulse_q, pulse_d;
  logic                         over_q, over_d;
  logic                         won_q, won_d;

  logic [AMOUNT_OF_ENEMIES-1:0] hit_mask_s;
  logic                         hit_valid_s;
  logic                         frame_done_s;
  logic [SPEED_W-1:0]           spawn_speed_s;

  // An id at or beyond the enemy count shifts the single bit out of the mask,
  // so out-of-range ids never match an alive enemy.
  assign hit_mask_s    = ID0_MASK << hitId;
  assign hit_valid_s   = hitPulse && ((alive_q & hit_mask_s) != '0);
  assign spawn_speed_s = wave_speed(wave_q, 12'(ENEMY_INITIAL_SPEED), 12'(SPEED_STEP),
                                    12'(MAX_SPEED), SPEEDUP_EN);

  // The delay restarts from zero every time CLEAR is entered.
  frame_delay_counter #(
    .TERMINAL (CLEAR_DELAY_FRAMES)
  ) u_clear_delay (
    .clk      (clk),
    .resetN   (resetN),
    .clear_i  (state_q != CLEAR),
    .enable_i (state_q == CLEAR),
    .frame_i  (startOfFrame),
    .done_o   (frame_done_s)
  );

  // Next-state and next-output logic for the wave controller.
  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    speed_d = speed_q;
    wave_d  = wave_q;
    kill_d  = kill_q;
    pulse_d = 1'b0;
    over_d  = over_q;
    won_d   = won_q;
    case (state_q)
      IDLE: begin
        if (startGame) state_d = SPAWN;
        else           state_d = IDLE;
      end
      SPAWN: begin
        alive_d = ALL_ALIVE;
        speed_d = spawn_speed_s;
        pulse_d = 1'b1;
        state_d = PLAY;
      end
      PLAY: begin
        // A landing ends the game even if a hit arrives in the same cycle.
        if (enemyLanded) begin
          state_d = OVER;
          alive_d = '0;
          over_d  = 1'b1;
        end else if (alive_q == '0) begin
          state_d = CLEAR;
        end else if (hit_valid_s) begin
          alive_d = alive_q & ~hit_mask_s;
          if (kill_q != KILL_MAX) kill_d = kill_q + KILL_W'(1);
          else                    kill_d = kill_q;
        end else begin
          state_d = PLAY;
        end
      end
      CLEAR: begin
        if (frame_done_s) begin
          if (wave_q == LAST_WAVE) begin
            state_d = WIN;
            alive_d = '0;
            over_d  = 1'b1;
            won_d   = 1'b1;
          end else begin
            wave_d  = wave_q + 4'd1;
            state_d = SPAWN;
          end
        end else begin
          state_d = CLEAR;
        end
      end
      OVER, WIN: begin
        alive_d = '0;
        if (startGame) begin
          state_d = SPAWN;
          wave_d  = 4'd0;
          kill_d  = '0;
          over_d  = 1'b0;
          won_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      alive_q <= '0;
      speed_q <= INIT_SPEED;
      wave_q  <= 4'd0;
      kill_q  <= '0;
      pulse_q <= 1'b0;
      over_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      speed_q <= speed_d;
      wave_q  <= wave_d;
      kill_q  <= kill_d;
      pulse_q <= pulse_d;
      over_q  <= over_d;
      won_q   <= won_d;
    end
  end

  assign aliveMap       = alive_q;
  assign enemySpeed     = speed_q;
  assign waveNumber     = wave_q;
  assign killCount      = kill_q;
  assign waveStartPulse = pulse_q;
  assign gameOver       = over_q;
  assign gameWon        = won_q;

endmodule
